xbar_arbiter: RTL
=================

Name: xbar_arbiter

Overview:
Conflict-free scheduler in front of the MVU crossbar interconnect. The crossbar ORs together every source that targets the same destination, so simultaneous writes to one destination corrupt each other. This block accepts per-MVU send requests through valid/ready handshakes and grants, each cycle, a set of sources whose destination masks do not overlap, using round-robin priority. It drives the crossbar's send_to/send_en/send_addr/send_word from registered outputs.

Parameters:
N, 8, number of MVUs (sources and destinations); N>=1
W, 64, data word width
BADDR, 15, destination memory address width
CNTW, 32, stall counter width

Ports:
clk  input  1  clock
clr  input  1  reset: asynchronous, active-high
req_valid  input  N  per-source request valid
req_to  input  N*N  destination mask; bits [i*N +: N] belong to source i, bit j = destination j
req_addr  input  N*BADDR  per-source destination address
req_word  input  N*W  per-source data word
req_ready  output  N  combinational grant; a transfer occurs when req_valid[i]&req_ready[i]
halt  input  1  when high, no grants are issued (drain/configuration)
send_en  output  N  to crossbar, registered
send_to  output  N*N  to crossbar, registered
send_addr  output  N*BADDR  to crossbar, registered
send_word  output  N*W  to crossbar, registered
stall_cnt  output  CNTW  saturating count of cycles with at least one blocked request
busy  output  1  registered; high if any send_en bit is set

Behaviour:
- Reset (clr high, async): send_en=0, send_to=0, send_addr=0, send_word=0, stall_cnt=0, busy=0, rr pointer=0. req_ready is forced to 0 while clr is high.
- State: round-robin pointer ptr in [0,N-1], plus the output registers and stall_cnt.
- Grant computation (combinational, every cycle):
  - Scan sources in order ptr, ptr+1, …, wrapping mod N. Keep a claimed mask, initially 0.
  - A source s with req_valid[s] and a nonzero mask m is granted iff (m & claimed)==0; on grant, claimed |= m.
  - A multicast request is granted atomically: all destinations or none.
- Zero mask: req_valid[s] with req_to[s]==0 is granted unconditionally. It claims nothing and is consumed without producing a send (send_en[s]=0 next cycle). This is a drop.
- halt=1: req_ready=0 for all sources. Output registers load 0 on the next edge. ptr and stall_cnt hold.
- req_ready[s] = grant[s]. It does not depend on req_valid of other sources beyond the scan. Sources must hold valid, to, addr and word stable until the transfer occurs.
- Registered outputs (next edge), per source s:
  - If granted with nonzero mask: send_en[s]=1, send_to/addr/word[s] = the request fields.
  - Otherwise: send_en[s]=0 and all fields 0.
  - busy = |send_en_next.
- Latency: handshake in cycle t → send_en in cycle t+1 → crossbar recv_en in cycle t+2.
- Pointer update: if at least one nonzero-mask grant occurs, ptr = (first granted source in scan order + 1) mod N. Otherwise ptr holds. Zero-mask drops do not move ptr.
- Fairness guarantee: a continuously valid request is granted within N cycles, because each non-granting cycle moves ptr strictly closer to it in scan order.
- stall_cnt increments by 1 in any cycle where halt=0 and some source has req_valid=1 with a nonzero mask and is not granted. It saturates at 2^CNTW-1.
- Invariant checked by assertion: for every destination j, at most one s has send_en[s]&send_to[s*N+j].
- N=1: a single source is always granted when valid and halt=0; ptr stays 0.
- clr asserted mid-transfer: registered sends are lost (outputs cleared). Requesters retry after clr deasserts; no partial state is retained.

Test Plan:
- Unicast (N=4): src1 valid, to=4'b0100, addr=0x12, word=0xA5 → req_ready[1]=1 same cycle; next cycle send_en=4'b0010, send_to[1]=4'b0100, send_addr[1]=0x12, send_word[1]=0xA5; ptr=2.
- Conflict: src0 and src2 both target dest 3, held valid, ptr=0 → cycle 0 grants src0 (stall_cnt=1), cycle 1 grants src2; never both in one cycle (invariant holds).
- Multicast vs unicast: src3 to=4'b1111, src0 to=4'b0001, src1 to=4'b0010, all reissued continuously, ptr=0 → src3 is granted within 4 cycles; on src3's grant cycle no other source is granted.
- Disjoint parallel: src0→dest1, src1→dest2, src2→dest3, src3→dest0 all valid → all four granted in one cycle; send_en=4'b1111.
- Zero mask plus halt: src2 valid with to=0 → ready=1 and send_en[2]=0 next cycle, ptr unchanged. With halt=1 and all valid, ready=0 and send_en=0 next cycle, stall_cnt unchanged.
- Reset mid-operation and saturation: assert clr while send_en≠0 → all outputs 0 asynchronously and ptr=0. With CNTW=2 and 5 conflict cycles → stall_cnt=3.

Source files
------------

// File: rtl/xbar_arbiter.sv
// xbar_arbiter: conflict-free round-robin scheduler feeding the MVU crossbar.
// Ports: clk/clr (async active-high reset); req_valid/req_to/req_addr/req_word
// per-source requests with combinational req_ready grant; halt blocks all grants;
// send_en/send_to/send_addr/send_word registered crossbar drive; stall_cnt
// saturating count of cycles with a blocked request; busy = any send_en set.
module xbar_arbiter #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int CNTW  = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N-1:0]         req_valid,
  input  logic [N*N-1:0]       req_to,
  input  logic [N*BADDR-1:0]   req_addr,
  input  logic [N*W-1:0]       req_word,
  output logic [N-1:0]         req_ready,
  input  logic                 halt,
  output logic [N-1:0]         send_en,
  output logic [N*N-1:0]       send_to,
  output logic [N*BADDR-1:0]   send_addr,
  output logic [N*W-1:0]       send_word,
  output logic [CNTW-1:0]      stall_cnt,
  output logic                 busy
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N-1:0]       en_q, en_d;
  logic [N*N-1:0]     to_q, to_d;
  logic [N*BADDR-1:0] addr_q, addr_d;
  logic [N*W-1:0]     word_q, word_d;
  logic [CNTW-1:0]    stall_q, stall_d;
  logic               busy_q, busy_d;
  logic [N-1:0]       grant, claimed, m;
  logic               found, blocked;
  int                 first, s;
  always_comb begin
    grant   = '0;
    claimed = '0;
    m       = '0;
    found   = 1'b0;
    blocked = 1'b0;
    first   = 0;
    s       = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr_q) + k;
      s = s >= N ? s - N : s;
      m = req_to[s*N +: N];
      if (!halt && req_valid[s]) begin
        // an empty mask is a drop: always accepted, claims no destination
        if (m == '0) grant[s] = 1'b1;
        else if ((m & claimed) == '0) begin
          grant[s] = 1'b1;
          claimed  = claimed | m;
          first    = found ? first : s;
          found    = 1'b1;
        end else blocked = 1'b1;
      end
    end
    en_d   = '0;
    to_d   = '0;
    addr_d = '0;
    word_d = '0;
    for (int i = 0; i < N; i++) begin
      en_d[i]                 = grant[i] & |req_to[i*N +: N];
      to_d[i*N +: N]          = en_d[i] ? req_to[i*N +: N] : '0;
      addr_d[i*BADDR +: BADDR] = en_d[i] ? req_addr[i*BADDR +: BADDR] : '0;
      word_d[i*W +: W]        = en_d[i] ? req_word[i*W +: W] : '0;
    end
    busy_d  = |en_d;
    // restart the scan just past the first real grant so everyone gets a turn
    ptr_d   = found ? PW'((first + 1) % N) : ptr_q;
    stall_d = blocked && stall_q != '1 ? stall_q + CNTW'(1) : stall_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q   <= '0;
      en_q    <= '0;
      to_q    <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end
  assign req_ready = clr ? '0 : grant;
  assign send_en   = en_q;
  assign send_to   = to_q;
  assign send_addr = addr_q;
  assign send_word = word_q;
  assign stall_cnt = stall_q;
  assign busy      = busy_q;
endmodule
